// File: rtl/gpio_irq_master.sv
// gpio_irq_master: after reset, writes two configuration registers into a gpio
//   peripheral. It then services the gpio level interrupt: it reads the vector
//   register, queues a nonzero vector in an event FIFO, and writes 0 back.
// Latency: irq seen at edge N -> read N..N+1, clear N+1..N+2, IDLE again at N+3.
// Backpressure: ev_ready low lets the FIFO fill. A nonzero vector that arrives
//   while the FIFO is full with no pop is dropped and sets sticky ovf. The gpio
//   is still cleared.
// Ports:
//   clk, rstn (async, active-high)  clock and reset
//   addr/we/wd (out), rd (in)       gpio simple register bus, outputs registered
//   irq (in)                        gpio interrupt, level
//   ev_valid/ev_ready/ev_data       event stream, FIFO head
//   init_done, busy, ovf            status
module gpio_irq_master #(
  parameter int          gpio_w     = 8,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] CFG0_ADDR  = 32'h0C,
  parameter logic [31:0] CFG0_DATA  = 32'h03,
  parameter logic [31:0] CFG1_ADDR  = 32'h10,
  parameter logic [31:0] CFG1_DATA  = 32'h02,
  parameter logic [31:0] IRQV_ADDR  = 32'h14
) (
  input  logic              clk,
  input  logic              rstn,
  output logic [31:0]       addr,
  output logic              we,
  output logic [31:0]       wd,
  input  logic [31:0]       rd,
  input  logic              irq,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [gpio_w-1:0] ev_data,
  output logic              init_done,
  output logic              busy,
  output logic              ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_START,
    S_INIT0,
    S_INIT1,
    S_IDLE,
    S_READ,
    S_CLEAR,
    S_HOLD
  } state_t;

  state_t state;

  // Event FIFO. Each pointer carries an extra wrap bit, so full and empty can
  // be told apart when the index bits are equal.
  logic [gpio_w-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;
  logic [gpio_w-1:0] vec;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign vec   = rd[gpio_w-1:0];

  assign ev_valid = !empty;
  assign ev_data  = empty ? '0 : mem[rptr[AW-1:0]];
  assign pop      = ev_valid && ev_ready;

  // A pop on the same edge frees the head slot, so a push into a full FIFO
  // is still accepted in that case.
  assign push = (state == S_READ) && (vec != '0) && (!full || pop);
  assign drop = (state == S_READ) && (vec != '0) && full && !pop;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
      if (drop) ovf  <= 1'b1;
    end
  end

  // The storage needs no reset: ev_data is forced to 0 while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= vec;
  end

  // Sequencer. The bus outputs load on the edge that enters each state, so
  // they always describe the cycle the FSM is in.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state     <= S_START;
      addr      <= '0;
      we        <= 1'b0;
      wd        <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        S_START: begin
          state <= S_INIT0;
          addr  <= CFG0_ADDR;
          wd    <= CFG0_DATA;
          we    <= 1'b1;
        end
        S_INIT0: begin
          state <= S_INIT1;
          addr  <= CFG1_ADDR;
          wd    <= CFG1_DATA;
          we    <= 1'b1;
        end
        S_INIT1: begin
          state     <= S_IDLE;
          addr      <= '0;
          wd        <= '0;
          we        <= 1'b0;
          init_done <= 1'b1;
        end
        S_IDLE: begin
          if (irq) begin
            state <= S_READ;
            addr  <= IRQV_ADDR;
            wd    <= '0;
            we    <= 1'b0;
          end
        end
        S_READ: begin
          // The vector is captured by the FIFO logic on this same edge.
          state <= S_CLEAR;
          addr  <= IRQV_ADDR;
          wd    <= '0;
          we    <= 1'b1;
        end
        S_CLEAR: begin
          state <= S_HOLD;
          addr  <= '0;
          wd    <= '0;
          we    <= 1'b0;
        end
        S_HOLD: begin
          // Guard cycle: this gives the cleared gpio time to drop irq.
          state <= S_IDLE;
        end
        default: begin
          state <= S_START;
          addr  <= '0;
          wd    <= '0;
          we    <= 1'b0;
        end
      endcase
    end
  end

endmodule
